// File: rtl/fll_cfg_bridge.sv
// APB slave that forwards register accesses to an FLL over a 4-phase req/ack handshake.
// FLL accesses stall PREADY until the handshake completes or times out; STATUS and unmapped accesses answer with zero wait.
module fll_cfg_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_r_data_i,
    input  logic        fll_lock_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int            CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic          wrn_q, wrn_d;
    logic [1:0]    add_q, add_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          sticky_q, sticky_d;
    logic          abandon_q, abandon_d;
    logic          ack_meta_q, ack_s_q;
    logic          lock_meta_q, lock_s_q;

    logic       access;
    logic [2:0] sel;
    logic       fll_hit, status_hit, unmapped_hit;
    logic       timeout;
    logic       done_resp;
    logic       unused_paddr;

    assign unused_paddr = ^{PADDR[11:5], PADDR[1:0]};

    assign access       = PSEL & PENABLE;
    assign sel          = PADDR[4:2];
    assign fll_hit      = access & ~sel[2];
    assign status_hit   = access & (sel == 3'd4);
    assign unmapped_hit = access & sel[2] & (sel[1:0] != 2'd0);
    assign timeout      = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wrn_d     = wrn_q;
        add_d     = add_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        sticky_d  = sticky_q;
        abandon_d = abandon_q;
        case (state_q)
            S_IDLE: begin
                if (fll_hit) begin
                    state_d   = S_REQ;
                    req_d     = 1'b1;
                    wrn_d     = ~PWRITE;
                    add_d     = sel[1:0];
                    data_d    = PWDATA;
                    rdata_d   = 32'd0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    abandon_d = 1'b0;
                end
                if (status_hit && PWRITE && PWDATA[1]) begin
                    sticky_d = 1'b0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (!PSEL) abandon_d = 1'b1;
                // A seen ack always beats a coincident timeout.
                if (ack_s_q) begin
                    rdata_d = wrn_q ? fll_r_data_i : 32'd0;
                    req_d   = 1'b0;
                    state_d = S_DROP;
                end else if (timeout) begin
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DROP: begin
                cnt_d = cnt_q + CW'(1);
                if (!PSEL) abandon_d = 1'b1;
                if (!ack_s_q) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            wrn_q       <= 1'b1;
            add_q       <= 2'd0;
            data_q      <= 32'd0;
            rdata_q     <= 32'd0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            abandon_q   <= 1'b0;
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wrn_q       <= wrn_d;
            add_q       <= add_d;
            data_q      <= data_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            sticky_q    <= sticky_d;
            abandon_q   <= abandon_d;
            ack_meta_q  <= fll_ack_i;
            ack_s_q     <= ack_meta_q;
            lock_meta_q <= fll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // A handshake whose APB master walked away still finishes, but answers nobody.
    assign done_resp = (state_q == S_DONE) & ~abandon_q;

    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'd0;
        if (done_resp) begin
            PREADY  = 1'b1;
            PSLVERR = err_q;
            PRDATA  = rdata_q;
        end else if (state_q == S_IDLE) begin
            if (status_hit) begin
                PREADY = 1'b1;
                PRDATA = {30'd0, sticky_q, lock_s_q};
            end else if (unmapped_hit) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end
        end
    end

    assign fll_req_o  = req_q;
    assign fll_wrn_o  = wrn_q;
    assign fll_add_o  = add_q;
    assign fll_data_o = data_q;

endmodule

// File: tb/tb_fll_cfg_bridge.sv
// Directed bench for fll_cfg_bridge with a behavioural FLL (zero-delay, delayed or dead ack).
module tb_fll_cfg_bridge;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = 12'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        fll_req, fll_wrn;
    logic [1:0]  fll_add;
    logic [31:0] fll_data;
    logic        fll_ack;
    logic [31:0] fll_rdata = 32'h1234_5678;
    logic        fll_lock = 1'b0;

    int          mode = 0;
    logic        ack_dly = 1'b0;
    int          dcnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] r_rdata;
    logic        r_err;
    int          r_cyc;
    int          r_req_cyc;
    logic [1:0]  r_add;
    logic        r_wrn;
    logic [31:0] r_data;
    logic        r_stable;
    logic        r_quiet;

    always #5 clk = ~clk;

    fll_cfg_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr),
        .fll_req_o(fll_req), .fll_wrn_o(fll_wrn), .fll_add_o(fll_add),
        .fll_data_o(fll_data), .fll_ack_i(fll_ack),
        .fll_r_data_i(fll_rdata), .fll_lock_i(fll_lock)
    );

    // mode 0: ack follows req; mode 1: ack 5 cycles after req; mode 2: ack dead
    assign fll_ack = (mode == 0) ? fll_req : (mode == 1) ? ack_dly : 1'b0;

    always @(posedge clk) begin
        if (!fll_req) begin
            dcnt    <= 0;
            ack_dly <= 1'b0;
        end else if (dcnt == 4) begin
            ack_dly <= 1'b1;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] d);
        bit done;
        done = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        r_req_cyc = 0; r_stable = 1'b1; r_quiet = 1'b1; r_cyc = 0;
        r_rdata = 32'hx; r_err = 1'bx;
        for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
            #1;
            if (pready) begin
                r_cyc = cyc; r_rdata = prdata; r_err = pslverr; done = 1;
            end else begin
                if (prdata !== 32'd0 || pslverr !== 1'b0) r_quiet = 1'b0;
                if (fll_req) begin
                    if (r_req_cyc == 0) begin
                        r_add = fll_add; r_wrn = fll_wrn; r_data = fll_data;
                    end else if (fll_add !== r_add || fll_wrn !== r_wrn || fll_data !== r_data) begin
                        r_stable = 1'b0;
                    end
                    r_req_cyc++;
                end
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        int rdy_cnt;
        int req_cnt;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, fll_req}, 32'd0);
        chk("rst_wrn",   {31'd0, fll_wrn}, 32'd1);
        chk("rst_add",   {30'd0, fll_add}, 32'd0);
        chk("rst_data",  fll_data, 32'd0);
        chk("rst_ready", {31'd0, pready}, 32'd0);
        chk("rst_err",   {31'd0, pslverr}, 32'd0);
        chk("rst_rdata", prdata, 32'd0);
        rstn = 1'b1;

        // zero-delay FLL write
        mode = 0;
        apb(12'h004, 1'b1, 32'hA5A5_0001);
        chk("wr_cyc",    r_cyc, 8);
        chk("wr_err",    {31'd0, r_err}, 32'd0);
        chk("wr_rdata",  r_rdata, 32'd0);
        chk("wr_wrn",    {31'd0, r_wrn}, 32'd0);
        chk("wr_add",    {30'd0, r_add}, 32'd1);
        chk("wr_data",   r_data, 32'hA5A5_0001);
        chk("wr_stable", {31'd0, r_stable}, 32'd1);
        chk("wr_quiet",  {31'd0, r_quiet}, 32'd1);

        // delayed-ack FLL read
        mode = 1;
        apb(12'h00C, 1'b0, 32'hDEAD_BEEF);
        chk("rd_cyc",    r_cyc, 14);
        chk("rd_rdata",  r_rdata, 32'h1234_5678);
        chk("rd_err",    {31'd0, r_err}, 32'd0);
        chk("rd_wrn",    {31'd0, r_wrn}, 32'd1);
        chk("rd_add",    {30'd0, r_add}, 32'd3);
        chk("rd_stable", {31'd0, r_stable}, 32'd1);
        chk("rd_quiet",  {31'd0, r_quiet}, 32'd1);

        // unmapped
        apb(12'h018, 1'b0, 32'd0);
        chk("um_cyc",   r_cyc, 1);
        chk("um_err",   {31'd0, r_err}, 32'd1);
        chk("um_rdata", r_rdata, 32'd0);
        chk("um_req",   r_req_cyc, 0);
        chk("um_req_after", {31'd0, fll_req}, 32'd0);

        // dead FLL -> timeout, sticky bit
        mode = 2;
        apb(12'h008, 1'b1, 32'h0000_00FF);
        chk("to_req_cyc", r_req_cyc, 16);
        chk("to_cyc",     r_cyc, 18);
        chk("to_err",     {31'd0, r_err}, 32'd1);
        chk("to_rdata",   r_rdata, 32'd0);
        chk("to_req_low", {31'd0, fll_req}, 32'd0);
        apb(12'h010, 1'b0, 32'd0);
        chk("st_sticky",     r_rdata, 32'h2);
        chk("st_sticky_cyc", r_cyc, 1);
        chk("st_sticky_err", {31'd0, r_err}, 32'd0);
        apb(12'h010, 1'b1, 32'h2);
        chk("st_clr_cyc", r_cyc, 1);
        apb(12'h010, 1'b0, 32'd0);
        chk("st_cleared", r_rdata, 32'h0);

        // lock through synchronizer
        fll_lock = 1'b1;
        repeat (3) @(posedge clk);
        apb(12'h010, 1'b0, 32'd0);
        chk("st_lock",     r_rdata, 32'h1);
        chk("st_lock_cyc", r_cyc, 1);

        // master abandons mid-handshake
        mode = 1;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 12'h000; pwrite = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        rdy_cnt = 0; req_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (pready) rdy_cnt++;
            if (fll_req) req_cnt++;
        end
        chk("ab_no_ready", rdy_cnt, 0);
        chk("ab_req_seen", {31'd0, (req_cnt > 0)}, 32'd1);
        chk("ab_req_low",  {31'd0, fll_req}, 32'd0);
        apb(12'h010, 1'b0, 32'd0);
        chk("ab_idle_cyc", r_cyc, 1);
        chk("ab_idle_st",  r_rdata, 32'h1);

        // reset in the middle of REQ
        mode = 2;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 12'h004; pwrite = 1'b1; pwdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("mr_req_before", {31'd0, fll_req}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("mr_req_async", {31'd0, fll_req}, 32'd0);
        chk("mr_ready",     {31'd0, pready}, 32'd0);
        chk("mr_wrn",       {31'd0, fll_wrn}, 32'd1);
        psel = 1'b0; penable = 1'b0;
        mode = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        apb(12'h004, 1'b1, 32'hA5A5_0001);
        chk("mr_wr_cyc",  r_cyc, 8);
        chk("mr_wr_err",  {31'd0, r_err}, 32'd0);
        chk("mr_wr_wrn",  {31'd0, r_wrn}, 32'd0);
        chk("mr_wr_add",  {30'd0, r_add}, 32'd1);
        chk("mr_wr_data", r_data, 32'hA5A5_0001);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
